// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and instruction field offsets for the ALU issue stage
package alu_pkg;
   localparam logic [1:0] OP_LI  = 2'd0;
   localparam logic [1:0] OP_OR  = 2'd1;
   localparam logic [1:0] OP_AND = 2'd2;
   localparam logic [1:0] OP_ADD = 2'd3;

   localparam int OP_LSB = 6;
   localparam int RD_LSB = 4;
   localparam int RS_LSB = 2;
   localparam int RT_LSB = 0;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      WB
   } state_t;
endpackage

// File: rtl/regfile4x8.sv
// rtl/regfile4x8.sv - 4-entry register file: two read ports sampled at accept, one write port, combinational debug read
module regfile4x8 #(
   parameter int NREG = 4,
   parameter int W    = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rd_en,
   input  logic [1:0]   rs_sel,
   input  logic [1:0]   rt_sel,
   output logic [W-1:0] rs_data,
   output logic [W-1:0] rt_data,
   input  logic         we,
   input  logic [1:0]   wr_sel,
   input  logic [W-1:0] wr_data,
   input  logic [1:0]   dbg_sel,
   output logic [W-1:0] dbg_data
);
   logic [W-1:0] regs [NREG];

   assign dbg_data = regs[dbg_sel];

   // Read ports are registers so they double as the ALU operand registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         rs_data <= '0;
         rt_data <= '0;
      end else begin
         if (we) regs[wr_sel] <= wr_data;
         if (rd_en) begin
            rs_data <= regs[rs_sel];
            rt_data <= regs[rt_sel];
         end
      end
   end
endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - three-state issue/writeback sequencer wrapped around an external combinational 8-bit ALU
module alu_issue_seq
   import alu_pkg::*;
#(
   parameter int NREG = 4,
   parameter int W    = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_instr,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [1:0]   alu_op,
   input  logic [W-1:0] alu_out,
   input  logic         alu_carry,
   output logic         done,
   output logic         flag_z,
   output logic         flag_c,
   input  logic [1:0]   dbg_sel,
   output logic [W-1:0] dbg_data
);
   state_t       state;
   logic         accept;
   logic [1:0]   rd;
   logic [3:0]   imm;
   logic [W-1:0] result;
   logic         carry_res;

   assign accept = in_valid && in_ready;

   regfile4x8 #(.NREG(NREG), .W(W)) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (accept),
      .rs_sel   (in_instr[RS_LSB +: 2]),
      .rt_sel   (in_instr[RT_LSB +: 2]),
      .rs_data  (alu_a),
      .rt_data  (alu_b),
      .we       (state == WB),
      .wr_sel   (rd),
      .wr_data  (result),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         alu_op    <= OP_LI;
         done      <= 1'b0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         rd        <= '0;
         imm       <= '0;
         result    <= '0;
         carry_res <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (accept) begin
                  rd       <= in_instr[RD_LSB +: 2];
                  imm      <= in_instr[RT_LSB +: 4];
                  alu_op   <= in_instr[OP_LSB +: 2];
                  in_ready <= 1'b0;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               // Only ADD produces a meaningful carry; the other ops clear it.
               result    <= (alu_op == OP_LI) ? {{(W-4){1'b0}}, imm} : alu_out;
               carry_res <= (alu_op == OP_ADD) && alu_carry;
               done      <= 1'b1;
               state     <= WB;
            end
            WB: begin
               flag_z   <= (result == '0);
               flag_c   <= carry_res;
               done     <= 1'b0;
               in_ready <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - vector table, hand sequences and random stream checked against an instruction-level model
module tb_alu_issue_seq;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_instr;
   logic [7:0] alu_a, alu_b, alu_out;
   logic [1:0] alu_op;
   logic       alu_carry;
   logic       done, flag_z, flag_c;
   logic [1:0] dbg_sel;
   logic [7:0] dbg_data;

   int n_cmp = 0;
   int n_fail = 0;

   logic [7:0] m_regs [4];
   logic       m_z, m_c;

   typedef struct {
      logic [7:0] instr;
      logic [7:0] exp_val;
      logic       exp_z;
      logic       exp_c;
   } vec_t;
   vec_t tbl [18];

   always #5 clk = ~clk;

   // Stand-in for the external combinational ALU.
   always_comb begin
      alu_out   = alu_a;
      alu_carry = 1'b0;
      case (alu_op)
         2'd1: alu_out = alu_a | alu_b;
         2'd2: alu_out = alu_a & alu_b;
         2'd3: {alu_carry, alu_out} = alu_a + alu_b;
         default: ;
      endcase
   end

   alu_issue_seq #(.NREG(4), .W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_out   (alu_out),
      .alu_carry (alu_carry),
      .done      (done),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .dbg_sel   (dbg_sel),
      .dbg_data  (dbg_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_z = 1'b0;
      m_c = 1'b0;
   endtask

   task automatic model_exec(input logic [7:0] ins);
      int unsigned a, b, sum;
      logic [7:0] res;
      logic c;
      a = m_regs[ins[3:2]];
      b = m_regs[ins[1:0]];
      c = 1'b0;
      case (ins[7:6])
         2'd0: res = {4'h0, ins[3:0]};
         2'd1: res = 8'(a | b);
         2'd2: res = 8'(a & b);
         default: begin
            sum = a + b;
            res = 8'(sum % 256);
            c   = (sum >= 256);
         end
      endcase
      m_regs[ins[5:4]] = res;
      m_z = (res == 8'h00);
      m_c = c;
   endtask

   task automatic check_regs(input string name);
      for (int i = 0; i < 4; i++) begin
         dbg_sel = 2'(i);
         #1;
         check(name, dbg_data, m_regs[i]);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_done", done, 0);
      check("rst_flag_z", flag_z, 0);
      check("rst_flag_c", flag_c, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_alu_op", alu_op, 0);
      rst = 1'b0;
      model_reset();
      check_regs("rst_regs");
   endtask

   // Issue one instruction and check the whole N..N+3 timeline against the model.
   task automatic send(input logic [7:0] ins);
      int waited = 0;
      while (!in_ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check("ready_before_accept", in_ready, 1);
      in_valid = 1'b1;
      in_instr = ins;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_instr = 8'($urandom);
      @(negedge clk);
      check("exec_alu_op", alu_op, ins[7:6]);
      if (ins[7:6] != 2'd0) begin
         check("exec_alu_a", alu_a, m_regs[ins[3:2]]);
         check("exec_alu_b", alu_b, m_regs[ins[1:0]]);
      end
      check("exec_in_ready", in_ready, 0);
      check("exec_done", done, 0);
      @(negedge clk);
      check("wb_done", done, 1);
      check("wb_in_ready", in_ready, 0);
      model_exec(ins);
      @(negedge clk);
      check("post_done", done, 0);
      check("post_in_ready", in_ready, 1);
      check("post_flag_z", flag_z, m_z);
      check("post_flag_c", flag_c, m_c);
      dbg_sel = ins[5:4];
      #1;
      check("post_rd_val", dbg_data, m_regs[ins[5:4]]);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      logic [1:0] rd;

      rst = 1'b1;
      in_valid = 1'b0;
      in_instr = 8'h00;
      dbg_sel = 2'd0;
      model_reset();

      tbl[0]  = '{8'h12, 8'h02, 1'b0, 1'b0};
      tbl[1]  = '{8'h23, 8'h03, 1'b0, 1'b0};
      tbl[2]  = '{8'hF6, 8'h05, 1'b0, 1'b0};
      tbl[3]  = '{8'hB6, 8'h02, 1'b0, 1'b0};
      tbl[4]  = '{8'h01, 8'h01, 1'b0, 1'b0};
      tbl[5]  = '{8'hB4, 8'h00, 1'b1, 1'b0};
      tbl[6]  = '{8'h2F, 8'h0F, 1'b0, 1'b0};
      tbl[7]  = '{8'hEA, 8'h1E, 1'b0, 1'b0};
      tbl[8]  = '{8'hEA, 8'h3C, 1'b0, 1'b0};
      tbl[9]  = '{8'hEA, 8'h78, 1'b0, 1'b0};
      tbl[10] = '{8'hEA, 8'hF0, 1'b0, 1'b0};
      tbl[11] = '{8'h1F, 8'h0F, 1'b0, 1'b0};
      tbl[12] = '{8'h56, 8'hFF, 1'b0, 1'b0};
      tbl[13] = '{8'hC5, 8'hFE, 1'b0, 1'b1};
      tbl[14] = '{8'h70, 8'hFE, 1'b0, 1'b0};
      tbl[15] = '{8'h21, 8'h01, 1'b0, 1'b0};
      tbl[16] = '{8'hC6, 8'h00, 1'b1, 1'b1};
      tbl[17] = '{8'h30, 8'h00, 1'b1, 1'b0};

      @(negedge clk);
      do_reset();

      for (int i = 0; i < 18; i++) begin
         send(tbl[i].instr);
         rd = tbl[i].instr[5:4];
         dbg_sel = rd;
         #1;
         check($sformatf("tbl%0d_val", i), dbg_data, tbl[i].exp_val);
         check($sformatf("tbl%0d_z", i), flag_z, tbl[i].exp_z);
         check($sformatf("tbl%0d_c", i), flag_c, tbl[i].exp_c);
      end

      // in_valid held high for 9 cycles: ready pattern 1,0,0 and three accepts.
      acc = 0;
      in_valid = 1'b1;
      in_instr = 8'h05;
      for (int c = 0; c < 9; c++) begin
         check($sformatf("hold_ready_c%0d", c), in_ready, (c % 3 == 0) ? 1 : 0);
         if (in_valid && in_ready) acc++;
         @(negedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("hold_accepts", acc, 3);
      check("hold_ready_after", in_ready, 1);
      repeat (3) model_exec(8'h05);
      check_regs("hold_regs");

      // Reset during EXEC of ADD r3,r1,r2 drops the instruction.
      do_reset();
      send(8'h12);
      send(8'h23);
      in_valid = 1'b1;
      in_instr = 8'hF6;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("rstexec_in_ready", in_ready, 1);
      check("rstexec_done", done, 0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("rstexec_no_done", done, 0);
      end
      dbg_sel = 2'd3;
      #1;
      check("rstexec_r3", dbg_data, 0);
      check_regs("rstexec_regs");

      // Random stream with random idle gaps.
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send(8'($urandom));
      end
      check_regs("rand_regs");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
